// File: rtl/video_pkg.sv
// Shared video definitions: pixel format and PAL timing constants.
package video_pkg;
  localparam int RGB_W     = 9;
  localparam int PAL_LINE  = 448;
  localparam int PAL_LINES = 312;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  // Half-intensity pixel for the darkened alternate scanline.
  function automatic rgb_t rgb_dim(input rgb_t c);
    rgb_t d;
    d.r = c.r >> 1;
    d.g = c.g >> 1;
    d.b = c.b >> 1;
    return d;
  endfunction
endpackage

// File: rtl/scan_doubler_line_buffer.sv
// Ping-pong line store: two banks of 2^ADDR_W pixels; the bank is the address MSB.
module line_buffer
  import video_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic            clock,
  input  logic            i_we,
  input  logic [ADDR_W:0] i_wrAddr,
  input  rgb_t            i_wrData,
  input  logic            i_re,
  input  logic [ADDR_W:0] i_rdAddr,
  output rgb_t            o_rdData
);
  rgb_t r_mem [0:(2**(ADDR_W+1))-1];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_wrAddr] <= i_wrData;
    if (i_re) o_rdData <= r_mem[i_rdAddr];
  end
endmodule

// File: rtl/scan_doubler.sv
// 15 kHz -> 31 kHz line doubler: each input line is replayed twice at ce2x rate.
// Build option SCANLINES_EN darkens the second copy of every line.
module scan_doubler
  import video_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int HS_WIDTH = 52,
  parameter int MIN_LINE = 64,
  parameter int RST_LINE = 448
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             ce2x,
  input  logic [RGB_W-1:0] rgbIn,
  input  logic             hsIn,
  input  logic             vsIn,
  output logic [RGB_W-1:0] rgb,
  output logic [1:0]       sync
);
  localparam int                LEN_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] HS_END   = ADDR_W'(HS_WIDTH);
  localparam logic [LEN_W-1:0]  MIN_L    = LEN_W'(MIN_LINE);
  localparam logic [LEN_W-1:0]  RST_L    = LEN_W'(RST_LINE);
`ifdef SCANLINES_EN
  localparam bit SCANLINES = 1'b1;
`else
  localparam bit SCANLINES = 1'b0;
`endif

  logic              r_hsD, r_vsLat;
  logic              r_wrBank, r_wrFull;
  logic [ADDR_W-1:0] r_wrAddr, r_rdAddr, r_rdAddrD;
  logic [LEN_W-1:0]  r_lineLen;
  logic              r_half, r_halfD;

  logic              w_lineStart, w_we, w_rdWrap, w_hsAct;
  logic [LEN_W-1:0]  w_measLen, w_lenM1;
  rgb_t              w_ramData, w_pixOut;

  assign w_lineStart = ce & hsIn & ~r_hsD;
  assign w_we        = ce & ~w_lineStart & ~r_wrFull;
  // wrAddr stops at the last entry, so the measurement tops out at one full bank
  assign w_measLen   = {1'b0, r_wrAddr} + 1'b1;
  assign w_lenM1     = r_lineLen - 1'b1;
  assign w_rdWrap    = ({1'b0, r_rdAddr} == w_lenM1);
  assign w_hsAct     = (r_rdAddrD < HS_END);
  assign w_pixOut    = (SCANLINES && r_halfD) ? rgb_dim(w_ramData) : w_ramData;

  line_buffer #(.ADDR_W(ADDR_W)) u_buf (
    .clock    (clock),
    .i_we     (w_we),
    .i_wrAddr ({r_wrBank, r_wrAddr}),
    .i_wrData (rgbIn),
    .i_re     (ce2x),
    .i_rdAddr ({~r_wrBank, r_rdAddr}),
    .o_rdData (w_ramData)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hsD     <= 1'b0;
      r_vsLat   <= 1'b0;
      r_wrBank  <= 1'b0;
      r_wrFull  <= 1'b0;
      r_wrAddr  <= '0;
      r_lineLen <= RST_L;
    end else if (ce) begin
      r_hsD   <= hsIn;
      r_vsLat <= vsIn;
      if (w_lineStart) begin
        r_wrBank <= ~r_wrBank;
        r_wrAddr <= '0;
        r_wrFull <= 1'b0;
        if (w_measLen >= MIN_L) r_lineLen <= w_measLen;
      end else if (!r_wrFull) begin
        if (r_wrAddr == ADDR_MAX) r_wrFull <= 1'b1;
        else                      r_wrAddr <= r_wrAddr + 1'b1;
      end
    end
  end

  // A new input line restarts replay even when ce2x would otherwise advance it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdAddr  <= '0;
      r_half    <= 1'b0;
      r_rdAddrD <= '0;
      r_halfD   <= 1'b0;
    end else begin
      if (w_lineStart) begin
        r_rdAddr <= '0;
        r_half   <= 1'b0;
      end else if (ce2x) begin
        if (w_rdWrap) begin
          r_rdAddr <= '0;
          r_half   <= ~r_half;
        end else begin
          r_rdAddr <= r_rdAddr + 1'b1;
        end
      end
      if (ce2x) begin
        r_rdAddrD <= r_rdAddr;
        r_halfD   <= r_half;
      end
    end
  end

  // vsync only moves at an output line start so frames begin on a clean line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb  <= '0;
      sync <= 2'b11;
    end else if (ce2x) begin
      sync[0] <= ~w_hsAct;
      rgb     <= w_hsAct ? '0 : w_pixOut;
      if (r_rdAddrD == '0) sync[1] <= ~r_vsLat;
    end
  end
endmodule

// File: tb/tb_scan_doubler.sv
// Bench for scan_doubler: directed tables plus random lines against a line-replay model.
module tb_scan_doubler;
  logic       clock = 1'b0;
  logic       reset, ce, ce2x, hsIn, vsIn;
  logic [8:0] rgbIn, rgb;
  logic [1:0] sync;

  always #5 clock = ~clock;

  scan_doubler dut (
    .clock(clock), .reset(reset), .ce(ce), .ce2x(ce2x),
    .rgbIn(rgbIn), .hsIn(hsIn), .vsIn(vsIn), .rgb(rgb), .sync(sync)
  );

`ifdef SCANLINES_EN
  localparam bit SCN = 1'b1;
`else
  localparam bit SCN = 1'b0;
`endif

  int errors = 0, checks = 0;

  // Model: previous input lines held per bank, replay position = ticks since line start.
  int         m_mem [2][512];
  int         m_bank, m_cnt, m_len, m_t;
  bit         m_full, m_hsD, m_vsLat;
  int         p_addr, p_half, p_pix;
  logic [8:0] e_rgb;
  bit         e_known;
  logic [1:0] e_sync;

  int         c2, mism, mism_c2;
  logic [8:0] mism_rgb, mism_ergb;
  logic [1:0] mism_sync, mism_esync;
  logic [8:0] cap_rgb  [2048];
  logic [1:0] cap_sync [2048];
  bit         tb_vs;

  typedef struct {
    int         mode;
    logic [8:0] cval;
    int         vs_at;
    logic [8:0] exp1;
    logic [8:0] exp2;
    int         exp_vsfall;
  } vec_t;
  vec_t tab [3];

  function automatic logic [8:0] dimv(input logic [8:0] v, input int h);
    if (SCN && h != 0) return {1'b0, v[8:7], 1'b0, v[5:4], 1'b0, v[2:1]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic m_reset();
    m_bank = 0; m_cnt = 0; m_full = 0; m_len = 448; m_t = 0;
    m_hsD = 0; m_vsLat = 0;
    p_addr = 0; p_half = 0; p_pix = -1;
    e_rgb = 9'd0; e_known = 1; e_sync = 2'b11;
  endtask

  task automatic m_edge(input bit ce_, input bit c2x, input logic [8:0] pin, input bit hs, input bit vs);
    int a, h;
    bit hsl, ls;
    ls = ce_ && hs && !m_hsD;
    if (c2x) begin
      hsl       = p_addr < 52;
      e_sync[0] = !hsl;
      e_known   = hsl || (p_pix >= 0);
      e_rgb     = (hsl || p_pix < 0) ? 9'd0 : dimv(9'(p_pix), p_half);
      if (p_addr == 0) e_sync[1] = !m_vsLat;
      a = m_t % m_len;
      h = (m_t / m_len) % 2;
      p_addr = a; p_half = h; p_pix = m_mem[1-m_bank][a];
      m_t++;
    end
    if (ce_) begin
      m_vsLat = vs;
      m_hsD   = hs;
      if (ls) begin
        m_bank = 1 - m_bank;
        if (m_cnt + 1 >= 64) m_len = m_cnt + 1;
        m_cnt = 0; m_full = 0; m_t = 0;
      end else if (!m_full) begin
        m_mem[m_bank][m_cnt] = int'(pin);
        if (m_cnt == 511) m_full = 1;
        else m_cnt++;
      end
    end
  endtask

  task automatic step(input bit ce_, input bit c2x, input logic [8:0] pin, input bit hs);
    ce = ce_; ce2x = c2x; rgbIn = pin; hsIn = hs; vsIn = tb_vs;
    @(posedge clock);
    m_edge(ce_, c2x, pin, hs, tb_vs);
    @(negedge clock);
    if (c2x) begin
      c2++;
      if (c2 < 2048) begin cap_rgb[c2] = rgb; cap_sync[c2] = sync; end
      if (sync !== e_sync || (e_known && rgb !== e_rgb)) begin
        if (mism == 0) begin
          mism_c2 = c2; mism_rgb = rgb; mism_ergb = e_rgb; mism_sync = sync; mism_esync = e_sync;
        end
        mism++;
      end
    end
  endtask

  task automatic stream_check(input string name);
    if (mism != 0)
      $display("  first diff at tick %0d: rgb=%h want %h sync=%b want %b",
               mism_c2, mism_rgb, mism_ergb, mism_sync, mism_esync);
    check(name, mism, 0);
    mism = 0;
  endtask

  // One input line of len ce ticks; ce on phase 0, ce2x on phases 0 and 2.
  task automatic drive_line(input int len, input int mode, input logic [8:0] cval,
                            input int vs_at, input int hs_w, input int glitch_at);
    logic [8:0] pix;
    for (int k = 0; k < len; k++) begin
      if (mode == 0)      pix = 9'((k - 1) & 511);
      else if (mode == 1) pix = cval;
      else                pix = 9'($urandom);
      if (k == vs_at) tb_vs = 1'b1;
      for (int ph = 0; ph < 4; ph++) begin
        step(ph == 0, ph == 0 || ph == 2, pix, (k < hs_w) || (k == glitch_at));
        if (k == 0 && ph == 0) c2 = 0;
      end
    end
    stream_check("stream");
  endtask

  function automatic int hs_fall_after(input int from, input int lim);
    for (int c = from; c < lim; c++)
      if (cap_sync[c][0] === 1'b0 && cap_sync[c-1][0] === 1'b1) return c;
    return -1;
  endfunction

  initial begin
    int lows, bad, pulses, vf, len;
    tab[0] = '{0, 9'd0,   -1,  9'd300, SCN ? 9'h092 : 9'd300, -1};
    tab[1] = '{1, 9'h1FF, 200, 9'h1FF, SCN ? 9'h0DB : 9'h1FF, 450};
    tab[2] = '{1, 9'h0A5, -1,  9'h0A5, SCN ? 9'h052 : 9'h0A5, -1};
    for (int b = 0; b < 2; b++) for (int a = 0; a < 512; a++) m_mem[b][a] = -1;
    mism = 0; c2 = 0; tb_vs = 0;
    reset = 1; ce = 0; ce2x = 0; hsIn = 0; vsIn = 0; rgbIn = 0;
    repeat (4) @(negedge clock);
    check("reset_rgb", rgb, 0);
    check("reset_sync", sync, 2'b11);
    reset = 0;
    m_reset();

    drive_line(448, 2, 0, -1, 32, -1);
    drive_line(448, 2, 0, -1, 32, -1);
    drive_line(448, 2, 0, -1, 4, 20);
    check("glitch_keeps_len", hs_fall_after(50, 896), 490);
    drive_line(448, 2, 0, -1, 32, -1);
    drive_line(448, 2, 0, -1, 32, -1);

    for (int i = 0; i < 3; i++) begin
      drive_line(448, tab[i].mode, tab[i].cval, -1, 32, -1);
      drive_line(448, 2, 0, tab[i].vs_at, 32, -1);
      check("pix300_first", cap_rgb[302], tab[i].exp1);
      check("pix300_second", cap_rgb[750], tab[i].exp2);
      lows = 0; bad = 0; pulses = 0;
      for (int c = 1; c <= 896; c++) begin
        if (cap_sync[c][0] === 1'b0) begin
          lows++;
          if (cap_rgb[c] !== 9'd0) bad++;
          if (cap_sync[c-1][0] === 1'b1) pulses++;
        end
      end
      check("hs_low_ticks", lows, 104);
      check("hs_pulses", pulses, 2);
      check("blank_in_hs", bad, 0);
      if (tab[i].vs_at >= 0) begin
        vf = -1;
        for (int c = 896; c >= 1; c--) if (cap_sync[c][1] === 1'b0) vf = c;
        check("vs_fall_at_line_start", vf, tab[i].exp_vsfall);
        tb_vs = 0;
        drive_line(448, 2, 0, -1, 32, -1);
      end
    end

    for (int i = 0; i < 10; i++) begin
      if (i == 3)      len = 600;
      else if (i == 6) len = 40;
      else             len = $urandom_range(380, 520);
      tb_vs = ($urandom_range(0, 3) == 0);
      drive_line(len, $urandom_range(0, 2), 9'($urandom), -1, 32, -1);
    end
    tb_vs = 0;
    drive_line(448, 2, 0, -1, 32, -1);

    drive_line(60, 1, 9'h1FF, -1, 32, -1);
    @(posedge clock);
    #2 reset = 1;
    #1;
    check("midline_reset_rgb", rgb, 0);
    check("midline_reset_sync", sync, 2'b11);
    bad = 0;
    ce = 0; ce2x = 0; hsIn = 0;
    repeat (8) begin
      @(negedge clock);
      if (rgb !== 9'd0 || sync !== 2'b11) bad++;
    end
    check("reset_hold", bad, 0);
    reset = 0;
    m_reset();
    drive_line(10, 2, 0, -1, 4, -1);
    drive_line(300, 2, 0, -1, 32, -1);
    check("rst_len_kept", hs_fall_after(10, 600), 450);
    drive_line(448, 2, 0, -1, 32, -1);
    drive_line(448, 2, 0, -1, 32, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
